// File: rtl/store_rmw_writer.sv
// Store writer for a word-only data memory: sw writes directly, sb/sh do a
// read-modify-write of the aligned word. Misaligned or reserved ops finish with err.
module store_rmw_writer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] OP_SB = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic [1:0]        r_lane;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ready, r_rd_en, r_wr_en, r_done, r_err;
  logic              w_accept, w_bad;
  logic [DATA_W-1:0] w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // sb can never be misaligned; sh needs halfword alignment, sw word alignment.
  assign w_bad = (req_op == 2'b11) ||
                 ((req_op == OP_SH) && req_addr[0]) ||
                 ((req_op == OP_SW) && (req_addr[1:0] != 2'b00));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = w_bad ? S_ERR : ((req_op == OP_SW) ? S_WRITE : S_READ);
      S_READ:  w_next = S_WAIT;
      S_WAIT:  if (mem_rdata_valid) w_next = S_WRITE;
      S_WRITE: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_merged = mem_rdata;
    case (r_op)
      OP_SB:   w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      OP_SH:   if (r_lane[1]) w_merged[31:16] = r_wdata[15:0];
               else           w_merged[15:0]  = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  // Strobes are registered from the next state so they are clean and one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_op        <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_rd_en <= (w_next == S_READ);
      r_wr_en <= (w_next == S_WRITE);
      r_done  <= (w_next == S_WRITE) || (w_next == S_ERR);
      r_err   <= (w_next == S_ERR);
      if (w_accept) begin
        r_op       <= req_op;
        r_lane     <= req_addr[1:0];
        r_wdata    <= req_wdata;
        r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        if (req_op == OP_SW) r_mem_wdata <= req_wdata;
      end
      if ((r_state == S_WAIT) && mem_rdata_valid) r_mem_wdata <= w_merged;
    end
  end

  assign req_ready = r_ready;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = r_wr_en;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_store_rmw_writer.sv
// Bench for store_rmw_writer: a per-cycle timeline model of expected outputs
// plus literal checks of merged words and error results.
module tb_store_rmw_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_rd_en, mem_rdata_valid, mem_wr_en, done, err;

  store_rmw_writer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int last_busy = -10;

  // Timeline model: what each output must be, keyed by cycle number.
  bit          exp_busy[int];
  bit          exp_rd[int];
  bit          exp_wr[int];
  bit          exp_done[int];
  bit          exp_err[int];
  logic [31:0] exp_addr[int];
  logic [31:0] exp_wdata[int];
  logic [31:0] rsp_at[int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] op, input logic [31:0] addr,
                                             input logic [31:0] wd, input logic [31:0] rd);
    logic [7:0] b [4];
    int k;
    for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
    k = int'(addr[1:0]);
    case (op)
      2'd0: b[k] = wd[7:0];
      2'd1: begin b[k & 2] = wd[7:0]; b[(k & 2) + 1] = wd[15:8]; end
      default: return wd;
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic bit model_bad(input logic [1:0] op, input logic [31:0] addr);
    return (op == 2'd3) || (op == 2'd1 && (addr % 2) != 0) || (op == 2'd2 && (addr % 4) != 0);
  endfunction

  // Memory side: replay the scheduled responses.
  always @(negedge clk) begin
    #1;
    if (rsp_at.exists(cyc)) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = rsp_at[cyc];
    end else begin
      mem_rdata_valid = 1'b0;
      mem_rdata       = 32'h5A5A_5A5A;
    end
  end

  // Single compare process against the timeline model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready", 32'(req_ready), 32'(!exp_busy.exists(cyc)));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd.exists(cyc)));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_wr.exists(cyc)));
      chk("done",      32'(done),      32'(exp_done.exists(cyc)));
      if (exp_done.exists(cyc)) chk("err", 32'(err), 32'(exp_err.exists(cyc)));
      if (exp_addr.exists(cyc)) chk("mem_addr", mem_addr, exp_addr[cyc]);
      if (exp_wdata.exists(cyc)) chk("mem_wdata", mem_wdata, exp_wdata[cyc]);
    end
  end

  // Present a request (called just after a falling edge) and record its expected timeline.
  // d = memory response delay after the read strobe; d == 0 means no response is scheduled.
  task automatic present(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int d, input bit spur,
                         output int a, output int w);
    logic [31:0] al;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    a  = (cyc + 1 > last_busy + 2) ? cyc + 1 : last_busy + 2;
    al = addr & 32'hFFFF_FFFC;
    if (model_bad(op, addr)) begin
      w = a; exp_busy[a] = 1; exp_done[a] = 1; exp_err[a] = 1; last_busy = a;
    end else if (op == 2'd2) begin
      w = a; exp_busy[a] = 1; exp_done[a] = 1; exp_wr[a] = 1;
      exp_addr[a] = al; exp_wdata[a] = wd; last_busy = a;
    end else begin
      exp_rd[a] = 1;
      if (spur) rsp_at[a] = ~rd;
      if (d > 0) begin
        w = a + d + 1;
        rsp_at[a + d] = rd;
        for (int c = a; c <= w; c++) begin exp_busy[c] = 1; exp_addr[c] = al; end
        exp_wr[w] = 1; exp_done[w] = 1; exp_wdata[w] = model_word(op, addr, wd, rd);
        last_busy = w;
      end else begin
        w = -1;
        exp_busy[a] = 1; exp_addr[a] = al;
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  // Full transaction with literal check of the written word or error flag.
  task automatic run(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int d, input logic [31:0] lit, input bit lit_err);
    int a, w;
    present(op, addr, wd, rd, d, 1'b0, a, w);
    wait_cyc(a);
    req_valid = 1'b0;
    wait_cyc(w);
    chk("lit_done", 32'(done), 32'd1);
    chk("lit_err", 32'(err), 32'(lit_err));
    if (!lit_err) chk("lit_wdata", mem_wdata, lit);
    else          chk("lit_no_wr", 32'(mem_wr_en), 32'd0);
  endtask

  initial begin
    int a, w, a2, w2;
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, w, a2, w2;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_rdata_valid = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rd",    32'(mem_rd_en), 32'd0);
    chk("rst_wr",    32'(mem_wr_en), 32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_addr",  mem_addr,       32'd0);
    chk("rst_wdata", mem_wdata,      32'd0);
    @(negedge clk); #1; reset = 1'b0;
    wait_cyc(cyc + 2);

    run(2'd2, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);

    run(2'd0, 32'h2000, 32'h0000_00AA, 32'h1122_3344, 1, 32'h1122_33AA, 1'b0);
    run(2'd0, 32'h2001, 32'h0000_00AA, 32'h1122_3344, 1, 32'h1122_AA44, 1'b0);
    run(2'd0, 32'h2002, 32'h0000_00AA, 32'h1122_3344, 2, 32'h11AA_3344, 1'b0);
    run(2'd0, 32'h2003, 32'h0000_00AA, 32'h1122_3344, 1, 32'hAA22_3344, 1'b0);

    run(2'd1, 32'h3002, 32'hFFFF_BEEF, 32'h1234_5678, 1, 32'hBEEF_5678, 1'b0);
    run(2'd1, 32'h3000, 32'hFFFF_BEEF, 32'h1234_5678, 3, 32'h1234_BEEF, 1'b0);

    // Stray response while idle must be ignored.
    rsp_at[cyc + 1] = 32'hFFFF_FFFF;
    wait_cyc(cyc + 3);

    run(2'd1, 32'h3001, 32'h1111_2222, 32'h0, 0, 32'h0, 1'b1);
    run(2'd2, 32'h3006, 32'h3333_4444, 32'h0, 0, 32'h0, 1'b1);
    run(2'd3, 32'h3000, 32'h5555_6666, 32'h0, 0, 32'h0, 1'b1);

    // Delayed response, spurious valid in READ, request held high while busy.
    present(2'd0, 32'h2001, 32'h0000_00AA, 32'h1122_3344, 5, 1'b1, a, w);
    wait_cyc(a);
    present(2'd2, 32'h4000, 32'h0BAD_F00D, 32'h0, 0, 1'b0, a2, w2);
    wait_cyc(w);
    chk("delay_wdata", mem_wdata, 32'h1122_AA44);
    wait_cyc(a2);
    req_valid = 1'b0;
    chk("b2b_wdata", mem_wdata, 32'h0BAD_F00D);
    chk("b2b_wr", 32'(mem_wr_en), 32'd1);
    wait_cyc(cyc + 2);

    // Reset while waiting for the read response, then a late response.
    present(2'd0, 32'h2002, 32'h0000_00AA, 32'h1122_3344, 0, 1'b0, a, w);
    exp_busy[a + 1] = 1; exp_busy[a + 2] = 1;
    rsp_at[a + 2] = 32'h7777_7777;
    rsp_at[a + 3] = 32'h8888_8888;
    wait_cyc(a);
    req_valid = 1'b0;
    wait_cyc(a + 2);
    #1; reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_wr",    32'(mem_wr_en), 32'd0);
    chk("midrst_done",  32'(done),      32'd0);
    chk("midrst_rd",    32'(mem_rd_en), 32'd0);
    last_busy = a + 2;
    wait_cyc(a + 3);
    reset = 1'b0;
    run(2'd2, 32'h5008, 32'hCAFE_F00D, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
    wait_cyc(cyc + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_rmw_writer.md
Name: store_rmw_writer

Overview:
- Write-side counterpart of the data-memory byte/halfword load extractor.
- Accepts sb/sh/sw store requests from the MEM stage.
- Drives a word-only data memory:
  - sw is written directly.
  - sb/sh go through read-modify-write: read the aligned word, merge the byte/halfword lane, write it back.
- Reports completion and misalignment errors to the pipeline stall/exception logic.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width. Fixed at 32; lane math below assumes 4 bytes per word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  block idle and able to accept a request.
- req_op  input  2  00=sb, 01=sh, 10=sw, 11=reserved.
- req_addr  input  32  byte address of the store.
- req_wdata  input  32  store data from rt; low byte/halfword used for sb/sh.
- mem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rdata  input  32  read data from memory.
- mem_rdata_valid  input  1  mem_rdata valid this cycle.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wdata  output  32  full word to write.
- done  output  1  one-cycle pulse when the request completes.
- err  output  1  qualified by done; 1 = misaligned or reserved op, no memory write performed.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, req_ready=1.
  - mem_rd_en=0, mem_wr_en=0, done=0, err=0.
  - mem_addr=0, mem_wdata=0, internal latches=0.
- Handshake: request accepted on a rising edge where req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - On accept, latch op, addr, wdata; the inputs may change afterwards.
- Error check at accept; any error goes to ERR:
  - sh with addr[0]=1.
  - sw with addr[1:0]!=0.
  - op=11.
  - sb is never misaligned.
- States:
  - IDLE: ready=1. On accept go to ERR (error), WRITE (sw), or READ (sb/sh).
  - READ: mem_rd_en=1 for exactly this cycle, mem_addr=aligned address. Next state WAIT.
  - WAIT: hold mem_addr. On the edge where mem_rdata_valid=1, register merged word into mem_wdata, go to WRITE. Stays in WAIT indefinitely otherwise.
  - WRITE: mem_wr_en=1, done=1, err=0, mem_addr/mem_wdata stable. Next state IDLE.
  - ERR: done=1, err=1, mem_wr_en=0, mem_rd_en=0. Next state IDLE.
- mem_rdata_valid handling: ignored in every state except WAIT, including a response arriving in the READ cycle and stray responses in IDLE.
- Merge rules (k=addr[1:0]):
  - sb: the byte at bits [8k+7:8k] of mem_rdata is replaced by wdata[7:0]; other bytes are preserved.
  - sh, addr[1]=0: bits [15:0] replaced by wdata[15:0].
  - sh, addr[1]=1: bits [31:16] replaced by wdata[15:0].
  - sw: mem_wdata=wdata unchanged.
- Latency, counted from the accept edge T:
  - sw: mem_wr_en and done in cycle T+1.
  - sb/sh: mem_rd_en in cycle T+1. mem_wr_en/done one cycle after the edge sampling mem_rdata_valid=1 in WAIT. Minimum T+3 when memory responds one cycle after rd_en.
  - Error: done/err in cycle T+1.
- Back-to-back: a new request may be accepted the cycle after WRITE/ERR, once IDLE is re-entered and req_ready=1. Throughput is 1 request per 2 cycles minimum.
- Reset mid-operation:
  - Immediate return to IDLE; no write is issued and no done pulse is produced.
  - A late mem_rdata_valid after reset is ignored.
- Outputs are registered and glitch-free; strobes are never asserted for more than one cycle per request.

Test Plan:
- Reset, then sw addr=0x0000_1004, wdata=0xDEAD_BEEF -> cycle T+1: mem_wr_en=1, mem_addr=0x1004, mem_wdata=0xDEADBEEF, done=1, err=0; mem_rd_en never asserted.
- sb to each of addr 0x2000..0x2003 with wdata=0x0000_00AA, memory returning 0x1122_3344 -> mem_wdata = 0x112233AA, 0x1122AA44, 0x11AA3344, 0xAA223344 respectively; mem_addr=0x2000 each time.
- sh addr=0x3002, wdata=0xFFFF_BEEF, rdata=0x1234_5678 -> mem_wdata=0xBEEF5678. sh addr=0x3000 -> mem_wdata=0x1234BEEF.
- Errors:
  - sh addr=0x3001, sw addr=0x3006, and op=11 -> each gives done=1, err=1 at T+1, with no mem_rd_en or mem_wr_en.
  - req_valid held high while busy -> no second accept until IDLE.
- sb with memory response delayed 5 cycles in WAIT, plus a spurious mem_rdata_valid in the READ cycle -> block stays in WAIT and merges only the WAIT-cycle data; a second valid request in the cycle after done is accepted.
- Assert reset while in WAIT, then drive mem_rdata_valid=1 -> no mem_wr_en and no done; req_ready=1 immediately; next sw completes normally.
